// File: rtl/usb_pkg.sv
// USB receive-side shared types: PID codes, line levels, SYNC
// pattern and the CRC5/CRC16 parameters used by both directions.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [1:0] {
    BODY_NONE,
    BODY_TOKEN,
    BODY_DATA
  } body_t;

  typedef struct packed {
    logic v;
    logic b;
    logic se0;
    logic j;
    logic k;
    logic serr;
  } rx_bit_t;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_PAT = 8'b1000_0000;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [4:0]  CRC5_RES   = 5'b01100;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  function automatic logic [4:0] crc5_step(
    input logic [4:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic body_t pid_body(input logic [3:0] p);
    body_t r;
    r = BODY_NONE;
    if (p == PID_OUT || p == PID_IN || p == PID_SETUP)
      r = BODY_TOKEN;
    else if (p == PID_DATA0 || p == PID_DATA1)
      r = BODY_DATA;
    return r;
  endfunction

  function automatic logic pid_known(input logic [3:0] p);
    return p == PID_OUT   || p == PID_IN   ||
           p == PID_SETUP || p == PID_DATA0 ||
           p == PID_DATA1 || p == PID_ACK  ||
           p == PID_NAK   || p == PID_STALL;
  endfunction

endpackage

// File: rtl/usb_rx_decoder_line.sv
// Line front-end: J/K/SE0 decode, NRZI decode and bit unstuffing.
// Outputs are combinational from the current sample and local state.
module usb_nrzi_unstuff
  import usb_pkg::*;
#(
  parameter int STUFF_RUN = 6
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rx_en,
  input  logic    unstuff_en,
  input  logic    dp_in,
  input  logic    dm_in,
  output rx_bit_t rx
);

  localparam int CW = $clog2(STUFF_RUN + 1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbit;

  always_comb begin
    rx     = '0;
    prev_d = prev_q;
    cnt_d  = unstuff_en ? cnt_q : '0;
    dbit   = (dp_in == prev_q);
    if (!rx_en) begin
      prev_d = 1'b1;
      cnt_d  = '0;
    end else if (dp_in == dm_in) begin
      // SE1 is folded into SE0; line state is not tracked through it
      rx.se0 = 1'b1;
    end else begin
      prev_d = dp_in;
      rx.j   = dp_in;
      rx.k   = !dp_in;
      rx.b   = dbit;
      if (!unstuff_en) begin
        rx.v = 1'b1;
      end else if (cnt_q == CW'(STUFF_RUN)) begin
        cnt_d   = '0;
        rx.serr = dbit;
      end else begin
        rx.v  = 1'b1;
        cnt_d = dbit ? cnt_q + CW'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: packet FSM, field shifter, CRC checkers
// and the two-byte holdback that strips CRC16 from payload.
module usb_rx_decoder
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic       pkt_start,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       tok_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       pkt_done,
  output logic       pid_err,
  output logic       crc_err,
  output logic       stuff_err,
  output logic       len_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_BODY, S_EOP, S_ERR
  } state_t;

  state_t      state_q, state_d;
  body_t       body_q, body_d;
  logic [15:0] sr_q, sr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic [1:0]  nbuf_q, nbuf_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [1:0]  eop_q, eop_d;

  logic       pkt_start_q, pkt_start_d;
  logic [3:0] pid_q, pid_d;
  logic       pid_valid_q, pid_valid_d;
  logic [6:0] tok_addr_q, tok_addr_d;
  logic [3:0] tok_endp_q, tok_endp_d;
  logic       tok_valid_q, tok_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       pkt_done_q, pkt_done_d;
  logic       pid_err_q, pid_err_d;
  logic       crc_err_q, crc_err_d;
  logic       stuff_err_q, stuff_err_d;
  logic       len_err_q, len_err_d;

  rx_bit_t     rxb;
  logic        unstuff_en;
  logic [15:0] shifted;
  logic        byte_done;
  logic        len_bad;
  logic        crc_bad;
  logic [7:0]  pbyte;

  assign unstuff_en = (state_q == S_PID) || (state_q == S_BODY);

  usb_nrzi_unstuff #(
    .STUFF_RUN(STUFF_RUN)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .unstuff_en(unstuff_en),
    .dp_in     (dp_in),
    .dm_in     (dm_in),
    .rx        (rxb)
  );

  always_comb begin
    state_d  = state_q;
    body_d   = body_q;
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    nbytes_d = nbytes_q;
    nbuf_d   = nbuf_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    eop_d    = eop_q;

    pkt_start_d  = 1'b0;
    pid_d        = pid_q;
    pid_valid_d  = 1'b0;
    tok_addr_d   = tok_addr_q;
    tok_endp_d   = tok_endp_q;
    tok_valid_d  = 1'b0;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    pkt_done_d   = 1'b0;
    pid_err_d    = pid_err_q;
    crc_err_d    = crc_err_q;
    stuff_err_d  = stuff_err_q;
    len_err_d    = len_err_q;

    shifted   = {rxb.b, sr_q[15:1]};
    byte_done = rxb.v && (bcnt_q == 3'd7);
    pbyte     = shifted[15:8];

    len_bad = (bcnt_q != 3'd0);
    crc_bad = 1'b0;
    if (body_q == BODY_TOKEN) begin
      len_bad = len_bad || (nbytes_q != 4'd2);
      crc_bad = (crc5_q != CRC5_RES);
    end else if (body_q == BODY_DATA) begin
      // last two bytes are always the CRC16
      len_bad = len_bad || (nbytes_q < 4'd2) ||
                (int'(nbytes_q) > MAX_BYTES + 2);
      crc_bad = (crc16_q != CRC16_RES);
    end else begin
      len_bad = len_bad || (nbytes_q != 4'd0);
    end

    unique case (state_q)
      S_IDLE: begin
        if (rxb.k) begin
          state_d = S_SYNC;
          sr_d    = shifted;
          bcnt_d  = 3'd1;
        end
      end
      S_SYNC: begin
        if (rxb.se0) begin
          state_d = S_ERR;
          eop_d   = 2'd1;
        end else if (rxb.v) begin
          sr_d   = shifted;
          bcnt_d = bcnt_q + 3'd1;
          if (byte_done) begin
            eop_d = 2'd0;
            if (pbyte == SYNC_PAT) begin
              state_d     = S_PID;
              pkt_start_d = 1'b1;
              pid_err_d   = 1'b0;
              crc_err_d   = 1'b0;
              stuff_err_d = 1'b0;
              len_err_d   = 1'b0;
            end else begin
              state_d = S_ERR;
            end
          end
        end
      end
      S_PID: begin
        if (rxb.se0) begin
          state_d = S_ERR;
          eop_d   = 2'd1;
        end else if (rxb.serr) begin
          state_d     = S_ERR;
          stuff_err_d = 1'b1;
        end else if (rxb.v) begin
          sr_d   = shifted;
          bcnt_d = bcnt_q + 3'd1;
          if (byte_done) begin
            if (pbyte[3:0] == ~pbyte[7:4] &&
                pid_known(pbyte[3:0])) begin
              state_d     = S_BODY;
              pid_d       = pbyte[3:0];
              pid_valid_d = 1'b1;
              body_d      = pid_body(pbyte[3:0]);
              nbytes_d    = 4'd0;
              nbuf_d      = 2'd0;
              crc5_d      = CRC5_INIT;
              crc16_d     = CRC16_INIT;
            end else begin
              state_d   = S_ERR;
              pid_err_d = 1'b1;
            end
          end
        end
      end
      S_BODY: begin
        if (rxb.se0) begin
          state_d   = S_EOP;
          eop_d     = 2'd1;
          len_err_d = len_err_q || len_bad;
          crc_err_d = crc_err_q || crc_bad;
        end else if (rxb.serr) begin
          state_d     = S_ERR;
          stuff_err_d = 1'b1;
        end else if (rxb.v) begin
          sr_d    = shifted;
          bcnt_d  = bcnt_q + 3'd1;
          crc5_d  = crc5_step(crc5_q, rxb.b);
          crc16_d = crc16_step(crc16_q, rxb.b);
          if (byte_done) begin
            if (nbytes_q != 4'hF)
              nbytes_d = nbytes_q + 4'd1;
            if (body_q == BODY_DATA) begin
              if (nbuf_q == 2'd2) begin
                byte_data_d  = b0_q;
                byte_valid_d = 1'b1;
                b0_d         = b1_q;
                b1_d         = pbyte;
              end else if (nbuf_q == 2'd1) begin
                b1_d   = pbyte;
                nbuf_d = 2'd2;
              end else begin
                b0_d   = pbyte;
                nbuf_d = 2'd1;
              end
            end
          end
        end
      end
      S_EOP: begin
        if (rxb.se0) begin
          eop_d = 2'd2;
        end else if (rxb.j && eop_q == 2'd2) begin
          state_d     = S_IDLE;
          eop_d       = 2'd0;
          nbuf_d      = 2'd0;
          pkt_done_d  = 1'b1;
          tok_addr_d  = sr_q[6:0];
          tok_endp_d  = sr_q[10:7];
          tok_valid_d = (body_q == BODY_TOKEN) &&
                        !crc_err_q && !len_err_q;
        end else if (rxb.j || rxb.k) begin
          state_d = S_ERR;
          eop_d   = 2'd0;
        end
      end
      S_ERR: begin
        if (rxb.se0) begin
          eop_d = 2'd1;
        end else if (rxb.j && eop_q != 2'd0) begin
          state_d    = S_IDLE;
          eop_d      = 2'd0;
          nbuf_d     = 2'd0;
          pkt_done_d = 1'b1;
        end else if (rxb.j || rxb.k) begin
          eop_d = 2'd0;
        end
      end
    endcase

    if (!rx_en) begin
      state_d = S_IDLE;
      nbuf_d  = 2'd0;
      eop_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      body_q       <= BODY_NONE;
      sr_q         <= '0;
      bcnt_q       <= '0;
      nbytes_q     <= '0;
      nbuf_q       <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      crc5_q       <= CRC5_INIT;
      crc16_q      <= CRC16_INIT;
      eop_q        <= '0;
      pkt_start_q  <= 1'b0;
      pid_q        <= '0;
      pid_valid_q  <= 1'b0;
      tok_addr_q   <= '0;
      tok_endp_q   <= '0;
      tok_valid_q  <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      pid_err_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      stuff_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      body_q       <= body_d;
      sr_q         <= sr_d;
      bcnt_q       <= bcnt_d;
      nbytes_q     <= nbytes_d;
      nbuf_q       <= nbuf_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      crc5_q       <= crc5_d;
      crc16_q      <= crc16_d;
      eop_q        <= eop_d;
      pkt_start_q  <= pkt_start_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      tok_addr_q   <= tok_addr_d;
      tok_endp_q   <= tok_endp_d;
      tok_valid_q  <= tok_valid_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      pkt_done_q   <= pkt_done_d;
      pid_err_q    <= pid_err_d;
      crc_err_q    <= crc_err_d;
      stuff_err_q  <= stuff_err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign pkt_start  = pkt_start_q;
  assign pid        = pid_q;
  assign pid_valid  = pid_valid_q;
  assign tok_addr   = tok_addr_q;
  assign tok_endp   = tok_endp_q;
  assign tok_valid  = tok_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_done   = pkt_done_q;
  assign pid_err    = pid_err_q;
  assign crc_err    = crc_err_q;
  assign stuff_err  = stuff_err_q;
  assign len_err    = len_err_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: encodes packets onto DP/DM and
// matches DUT pulses against a queue of expected events.
module tb_usb_rx_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       dp_in;
  logic       dm_in;
  logic       pkt_start;
  logic [3:0] pid;
  logic       pid_valid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       tok_valid;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pkt_done;
  logic       pid_err;
  logic       crc_err;
  logic       stuff_err;
  logic       len_err;
  logic       rx_busy;

  localparam int EV_START = 1;
  localparam int EV_PID   = 2;
  localparam int EV_TOK   = 3;
  localparam int EV_BYTE  = 4;
  localparam int EV_DONE  = 5;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  bit          tx[$];
  logic [7:0]  pl[$];

  usb_rx_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .dp_in     (dp_in),
    .dm_in     (dm_in),
    .pkt_start (pkt_start),
    .pid       (pid),
    .pid_valid (pid_valid),
    .tok_addr  (tok_addr),
    .tok_endp  (tok_endp),
    .tok_valid (tok_valid),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .pkt_done  (pkt_done),
    .pid_err   (pid_err),
    .crc_err   (crc_err),
    .stuff_err (stuff_err),
    .len_err   (len_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ev(int k, logic [15:0] d);
    return {8'(k), 8'h00, d};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(string tag, logic [31:0] got);
    if (sb.size() == 0)
      check_eq({tag, "_unexpected"}, got, 32'hFFFF_FFFF);
    else
      check_eq(tag, got, sb.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_start)
        sb_pop("pkt_start", ev(EV_START, 16'h0));
      if (pid_valid)
        sb_pop("pid", ev(EV_PID, {12'h0, pid}));
      if (tok_valid)
        sb_pop("token", ev(EV_TOK, {5'h0, tok_endp, tok_addr}));
      if (byte_valid)
        sb_pop("byte", ev(EV_BYTE, {8'h0, byte_data}));
      if (pkt_done)
        sb_pop("pkt_done", ev(EV_DONE,
          {12'h0, pid_err, crc_err, stuff_err, len_err}));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic put_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) tx.push_back(v[i]);
  endtask

  task automatic put_token(logic [6:0] a, logic [3:0] e, bit flip);
    logic [10:0] f;
    logic [4:0]  c;
    logic        fb;
    f = {e, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = f[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      tx.push_back(f[i]);
    end
    c = ~c;
    if (flip) c[4] = ~c[4];
    for (int i = 4; i >= 0; i--) tx.push_back(c[i]);
  endtask

  task automatic put_data(bit flip);
    logic [15:0] c;
    logic        fb;
    logic [7:0]  v;
    c = 16'hFFFF;
    foreach (pl[n]) begin
      v = pl[n];
      for (int i = 0; i < 8; i++) begin
        fb = v[i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        tx.push_back(v[i]);
      end
    end
    c = ~c;
    if (flip) c[15] = ~c[15];
    for (int i = 15; i >= 0; i--) tx.push_back(c[i]);
  endtask

  task automatic drive(logic d, logic m);
    dp_in = d;
    dm_in = m;
    @(negedge clk);
  endtask

  // SYNC, stuffed+NRZI tx[], EOP; abort_at>=0 stops before tx[abort_at]
  task automatic send(bit drop_stuff, int abort_at, int idle);
    logic lvl;
    int   run;
    bit   dropped;
    lvl = 1'b1;
    run = 0;
    dropped = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 7) lvl = ~lvl;
      drive(lvl, ~lvl);
    end
    for (int i = 0; i < tx.size(); i++) begin
      if (i == abort_at) return;
      if (!tx[i]) lvl = ~lvl;
      drive(lvl, ~lvl);
      run = tx[i] ? run + 1 : 0;
      if (run == 6) begin
        run = 0;
        if (drop_stuff && !dropped) begin
          dropped = 1'b1;
        end else begin
          lvl = ~lvl;
          drive(lvl, ~lvl);
        end
      end
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (idle) drive(1'b1, 1'b0);
  endtask

  task automatic exp_head(logic [3:0] p, bit good);
    sb.push_back(ev(EV_START, 16'h0));
    if (good) sb.push_back(ev(EV_PID, {12'h0, p}));
  endtask

  task automatic exp_bytes();
    foreach (pl[n]) sb.push_back(ev(EV_BYTE, {8'h0, pl[n]}));
  endtask

  task automatic exp_done(logic [3:0] flags);
    sb.push_back(ev(EV_DONE, {12'h0, flags}));
  endtask

  task automatic exp_tok(logic [6:0] a, logic [3:0] e);
    sb.push_back(ev(EV_TOK, {5'h0, e, a}));
  endtask

  task automatic end_pkt(string tag);
    repeat (3) @(negedge clk);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 0);
    check_eq({tag, "_busy"}, 32'(rx_busy), 0);
  endtask

  task automatic token_pkt(string tag, logic [7:0] pb,
                           logic [6:0] a, logic [3:0] e);
    tx.delete();
    put_byte(pb);
    put_token(a, e, 1'b0);
    exp_head(pb[3:0], 1'b1);
    exp_tok(a, e);
    exp_done(4'b0000);
    send(1'b0, -1, 2);
    end_pkt(tag);
  endtask

  initial begin
    rst   = 1'b1;
    rx_en = 1'b1;
    dp_in = 1'b1;
    dm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs_a", 32'({pkt_start, pid, pid_valid,
             tok_addr, tok_endp, tok_valid}), 0);
    check_eq("rst_outs_b", 32'({byte_data, byte_valid, pkt_done,
             pid_err, crc_err, stuff_err, len_err, rx_busy}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    token_pkt("t1_out", 8'hE1, 7'h15, 4'hE);

    pl = '{8'h00, 8'h01, 8'h02, 8'h03};
    tx.delete(); put_byte(8'hC3); put_data(1'b0);
    exp_head(4'b0011, 1'b1); exp_bytes(); exp_done(4'b0000);
    send(1'b0, -1, 2);
    end_pkt("t2_data0");

    tx.delete(); put_byte(8'hC3); put_data(1'b1);
    exp_head(4'b0011, 1'b1); exp_bytes(); exp_done(4'b0100);
    send(1'b0, -1, 2);
    end_pkt("t2_crc_bad");

    pl = '{8'hFF, 8'hFF};
    tx.delete(); put_byte(8'h4B); put_data(1'b0);
    exp_head(4'b1011, 1'b1); exp_bytes(); exp_done(4'b0000);
    send(1'b0, -1, 2);
    end_pkt("t3_data1_ff");

    exp_head(4'b1011, 1'b1); exp_done(4'b0010);
    send(1'b1, -1, 2);
    end_pkt("t3_stuff_bad");

    token_pkt("t4_setup", 8'h2D, 7'h3A, 4'h1);

    tx.delete(); put_byte(8'h21); put_token(7'h3A, 4'h1, 1'b0);
    exp_head(4'h1, 1'b0); exp_done(4'b1000);
    send(1'b0, -1, 2);
    end_pkt("t4_pid_bad");

    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h10 + i));
    tx.delete(); put_byte(8'hC3); put_data(1'b0);
    exp_head(4'b0011, 1'b1); exp_bytes(); exp_done(4'b0001);
    send(1'b0, -1, 2);
    end_pkt("t5_len");

    pl.delete();
    tx.delete(); put_byte(8'hC3); put_data(1'b0);
    exp_head(4'b0011, 1'b1); exp_done(4'b0000);
    send(1'b0, -1, 2);
    end_pkt("t5_zero_len");

    exp_head(4'b0010, 1'b1); exp_done(4'b0000);
    exp_head(4'b1010, 1'b1); exp_done(4'b0000);
    tx.delete(); put_byte(8'hD2);
    send(1'b0, -1, 0);
    tx.delete(); put_byte(8'h5A);
    send(1'b0, -1, 2);
    end_pkt("t5_ack_nak");

    pl = '{8'h00, 8'h01, 8'h02, 8'h03};
    tx.delete(); put_byte(8'hC3); put_data(1'b0);
    exp_head(4'b0011, 1'b1);
    send(1'b0, 28, 0);
    rx_en = 1'b0;
    dp_in = 1'b1;
    dm_in = 1'b0;
    @(negedge clk);
    check_eq("t6_en_busy", 32'(rx_busy), 0);
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    @(negedge clk);
    end_pkt("t6_en_abort");
    token_pkt("t6_en_after", 8'h69, 7'h7F, 4'h5);

    tx.delete(); put_byte(8'hC3); put_data(1'b0);
    exp_head(4'b0011, 1'b1);
    send(1'b0, 28, 0);
    rst   = 1'b1;
    dp_in = 1'b1;
    dm_in = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_busy", 32'(rx_busy), 0);
    check_eq("t6_rst_pid", 32'(pid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    end_pkt("t6_rst_abort");
    token_pkt("t6_rst_after", 8'hE1, 7'h01, 4'h2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
